adc_sample_capture: RTL and testbench



---
 rtl/adc_capture_pkg.sv | 30 +++
 rtl/adc_capture_fifo.sv | 46 ++++
 rtl/adc_sample_capture.sv | 181 ++++++++++++++++++
 tb/tb_adc_sample_capture.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// rtl/adc_capture_pkg.sv - register map, field positions and sample type for adc_sample_capture
package adc_capture_pkg;

  localparam int SAMPLE_W = 10;

  localparam logic [1:0] CTRL_OFS   = 2'd0;
  localparam logic [1:0] STATUS_OFS = 2'd1;
  localparam logic [1:0] DATA_OFS   = 2'd2;
  localparam logic [1:0] THRESH_OFS = 2'd3;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_K_LSB      = 1;
  localparam int CTRL_FLUSH_BIT  = 8;
  localparam int CTRL_IRQ_EN_BIT = 9;

  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_THR_BIT   = 3;
  localparam int STAT_LEVEL_LSB = 4;

  localparam int THRESH_TEN_BIT = 16;

  typedef logic [SAMPLE_W-1:0] sample_t;

  function automatic logic [2:0] clamp_k(input logic [2:0] k_in, input int unsigned k_max);
    return (32'(k_in) > k_max) ? 3'(k_max) : k_in;
  endfunction

endpackage

// File: rtl/adc_capture_fifo.sv
// rtl/adc_capture_fifo.sv - synchronous FIFO for averaged words; pop frees a slot for a same-cycle push
module adc_capture_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  assign level   = wptr - rptr;
  assign empty   = (wptr == rptr);
  assign full    = (level == (AW+1)'(DEPTH));
  assign head    = mem[rptr[AW-1:0]];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/adc_sample_capture.sv
// rtl/adc_sample_capture.sv - 2^k sample averager, FIFO and Wishbone slave with IRQ
// Optional threshold detector enabled by defining ADC_CAPTURE_THRESH_EN.
module adc_sample_capture
  import adc_capture_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int          DATA_W       = SAMPLE_W,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          MAX_LOG2_AVG = 4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [DATA_W-1:0] sample_i,
  input  logic              sample_valid_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              irq_o
);
  localparam int ACC_W = DATA_W + MAX_LOG2_AVG;
  localparam int CNT_W = MAX_LOG2_AVG + 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              en, irq_en, ovf, thr;
  logic [2:0]        k;
  logic              hit, ctrl_wr, status_wr, thresh_wr, pop, flush;
  logic [1:0]        reg_sel;
  logic              en_nxt, win_clear, win_done;
  logic [2:0]        k_nxt;
  logic [ACC_W-1:0]  acc, acc_sum, avg;
  logic [CNT_W-1:0]  cnt, cnt_inc;
  logic              push_valid;
  logic [DATA_W-1:0] push_word, head;
  logic [LVL_W-1:0]  level;
  logic              full, empty, pop_ok;
  logic [31:0]       rd_data, thresh_rd;
  logic              unused_in;

  assign hit       = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign reg_sel   = wbs_adr_i[3:2];
  assign ctrl_wr   = hit & wbs_we_i & (reg_sel == CTRL_OFS);
  assign status_wr = hit & wbs_we_i & (reg_sel == STATUS_OFS);
  assign thresh_wr = hit & wbs_we_i & (reg_sel == THRESH_OFS);
  assign pop       = hit & ~wbs_we_i & (reg_sel == DATA_OFS);
  assign flush     = ctrl_wr & wbs_sel_i[1] & wbs_dat_i[CTRL_FLUSH_BIT];
  assign pop_ok    = pop & ~empty;
  assign unused_in = ^{wbs_sel_i[3:2], wbs_dat_i, wbs_adr_i[1:0]};

  // Any write that disables capture or changes K discards the partial window.
  assign en_nxt    = (ctrl_wr & wbs_sel_i[0]) ? wbs_dat_i[CTRL_EN_BIT] : en;
  assign k_nxt     = (ctrl_wr & wbs_sel_i[0]) ?
                     clamp_k(wbs_dat_i[CTRL_K_LSB +: 3], MAX_LOG2_AVG) : k;
  assign win_clear = flush | ~en_nxt | (k_nxt != k);

  assign acc_sum  = acc + ACC_W'(sample_i);
  assign cnt_inc  = cnt + 1'b1;
  assign win_done = (cnt_inc == (CNT_W'(1) << k));
  assign avg      = acc_sum >> k;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      en     <= 1'b0;
      k      <= '0;
      irq_en <= 1'b0;
    end else if (ctrl_wr) begin
      en <= en_nxt;
      k  <= k_nxt;
      if (wbs_sel_i[1]) irq_en <= wbs_dat_i[CTRL_IRQ_EN_BIT];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      acc        <= '0;
      cnt        <= '0;
      push_valid <= 1'b0;
      push_word  <= '0;
    end else begin
      push_valid <= 1'b0;
      if (win_clear) begin
        acc <= '0;
        cnt <= '0;
      end else if (sample_valid_i) begin
        if (win_done) begin
          acc        <= '0;
          cnt        <= '0;
          push_valid <= 1'b1;
          push_word  <= avg[DATA_W-1:0];
        end else begin
          acc <= acc_sum;
          cnt <= cnt_inc;
        end
      end
    end
  end

  adc_capture_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (push_valid),
    .pop   (pop),
    .flush (flush),
    .din   (push_word),
    .head  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) ovf <= 1'b0;
    else if (push_valid & full & ~pop_ok & ~flush) ovf <= 1'b1;
    else if (status_wr & wbs_sel_i[0] & wbs_dat_i[STAT_OVF_BIT]) ovf <= 1'b0;
  end

`ifdef ADC_CAPTURE_THRESH_EN
  logic [DATA_W-1:0] thr_level;
  logic              thr_en;
  logic              push_ok;

  assign push_ok   = push_valid & ~flush & (~full | pop_ok);
  assign thresh_rd = 32'(thr_level) | (32'(thr_en) << THRESH_TEN_BIT);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      thr_level <= '0;
      thr_en    <= 1'b0;
      thr       <= 1'b0;
    end else begin
      if (thresh_wr) begin
        if (wbs_sel_i[0]) thr_level[7:0]        <= wbs_dat_i[7:0];
        if (wbs_sel_i[1]) thr_level[DATA_W-1:8] <= wbs_dat_i[DATA_W-1:8];
        if (wbs_sel_i[2]) thr_en                <= wbs_dat_i[THRESH_TEN_BIT];
      end
      if (push_ok & thr_en & (push_word >= thr_level)) thr <= 1'b1;
      else if (status_wr & wbs_sel_i[0] & wbs_dat_i[STAT_THR_BIT]) thr <= 1'b0;
    end
  end
`else
  assign thr       = 1'b0;
  assign thresh_rd = '0;
`endif

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      CTRL_OFS: begin
        rd_data[CTRL_EN_BIT]       = en;
        rd_data[CTRL_K_LSB +: 3]   = k;
        rd_data[CTRL_IRQ_EN_BIT]   = irq_en;
      end
      STATUS_OFS: begin
        rd_data[STAT_EMPTY_BIT]            = empty;
        rd_data[STAT_FULL_BIT]             = full;
        rd_data[STAT_OVF_BIT]              = ovf;
        rd_data[STAT_THR_BIT]              = thr;
        rd_data[STAT_LEVEL_LSB +: LVL_W]   = level;
      end
      DATA_OFS:   if (!empty) rd_data[DATA_W-1:0] = head;
      default:    rd_data = thresh_rd;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      irq_o     <= 1'b0;
    end else begin
      wbs_ack_o <= hit;
      wbs_dat_o <= (hit & ~wbs_we_i) ? rd_data : '0;
      irq_o     <= irq_en & (~empty | ovf | thr);
    end
  end

endmodule

// File: tb/tb_adc_sample_capture.sv
// tb/tb_adc_sample_capture.sv - scoreboard bench for adc_sample_capture (directed vectors)
module tb_adc_sample_capture;
  import adc_capture_pkg::*;

  localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef ADC_CAPTURE_THRESH_EN
  localparam bit THR_ON = 1'b1;
`else
  localparam bit THR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  sample_t     sample = '0;
  logic        sample_valid = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack;
  logic [31:0] rdat;
  logic        irq;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    bit          chk;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];

  adc_sample_capture dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .sample_i       (sample),
    .sample_valid_i (sample_valid),
    .wbs_cyc_i      (cyc),
    .wbs_stb_i      (stb),
    .wbs_we_i       (we),
    .wbs_sel_i      (sel),
    .wbs_adr_i      (adr),
    .wbs_dat_i      (wdat),
    .wbs_ack_o      (ack),
    .wbs_dat_o      (rdat),
    .irq_o          (irq)
  );

  always #5 clk = ~clk;

  // Monitor: every ack consumes one scoreboard entry; reads are compared.
  always @(negedge clk) begin
    if (ack) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_ack got=%h want=no_ack", rdat);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.chk) begin
          total++;
          if (rdat !== e.val) begin
            bad++;
            $display("FAIL %s got=%h want=%h", e.name, rdat, e.val);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus(input bit w, input logic [1:0] r, input logic [31:0] d,
                     input logic [3:0] s, input logic [31:0] expv, input string name);
    int   n;
    exp_t e;
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; wdat = d;
    adr = BASE | {28'd0, r, 2'b00};
    e.name = name; e.chk = !w; e.val = expv;
    exp_q.push_back(e);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ack && n < 8);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    total++;
    if (n != 1) begin
      bad++;
      $display("FAIL %s_ack_latency got=%0d want=1", name, n);
      if (!ack && exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
    end
    idle(1);
  endtask

  task automatic wr(input logic [1:0] r, input logic [31:0] d, input logic [3:0] s, input string name);
    bus(1'b1, r, d, s, 32'd0, name);
  endtask

  task automatic rd(input logic [1:0] r, input logic [31:0] expv, input string name);
    bus(1'b0, r, 32'd0, 4'hF, expv, name);
  endtask

  task automatic drive_sample(input sample_t v);
    sample = v; sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    idle(3);
    check("reset_ack", {31'd0, ack}, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_dat", rdat, 32'd0);
    rst = 1'b0;
    rd(STATUS_OFS, 32'h1, "status_after_reset");

    // K=0 pass-through, IRQ follows FIFO occupancy
    wr(CTRL_OFS, 32'h201, 4'hF, "ctrl_k0");
    drive_sample(10'h3FF);
    drive_sample(10'h001);
    idle(3);
    check("irq_pending", {31'd0, irq}, 32'd1);
    rd(DATA_OFS, 32'h3FF, "data_k0_first");
    check("irq_one_left", {31'd0, irq}, 32'd1);
    rd(DATA_OFS, 32'h001, "data_k0_second");
    check("irq_drained", {31'd0, irq}, 32'd0);
    rd(DATA_OFS, 32'h0, "data_empty_read");
    rd(STATUS_OFS, 32'h1, "status_after_empty_read");

    // K=2 averaging, then a discarded partial window
    wr(CTRL_OFS, 32'h5, 4'hF, "ctrl_k2");
    drive_sample(10'd4); drive_sample(10'd5); drive_sample(10'd6); drive_sample(10'd8);
    idle(3);
    rd(DATA_OFS, 32'd5, "data_avg4");
    drive_sample(10'd1); drive_sample(10'd2); drive_sample(10'd3);
    wr(CTRL_OFS, 32'h0, 4'hF, "ctrl_disable");
    wr(CTRL_OFS, 32'h5, 4'hF, "ctrl_reenable");
    for (int i = 0; i < 4; i++) drive_sample(10'd8);
    idle(3);
    rd(DATA_OFS, 32'd8, "data_after_discard");
    rd(STATUS_OFS, 32'h1, "status_after_discard");

    // Overflow, flush keeps OVF, W1C clears it, K clamp
    wr(CTRL_OFS, 32'h1, 4'hF, "ctrl_k0_en");
    for (int i = 0; i < 9; i++) drive_sample(sample_t'(10'h10 + i));
    idle(3);
    rd(STATUS_OFS, 32'h86, "status_full_ovf");
    rd(DATA_OFS, 32'h10, "data_head_first");
    wr(CTRL_OFS, 32'h101, 4'hF, "ctrl_flush");
    rd(STATUS_OFS, 32'h5, "status_flush_keeps_ovf");
    wr(STATUS_OFS, 32'h4, 4'hF, "status_ovf_clear");
    rd(STATUS_OFS, 32'h1, "status_ovf_cleared");
    rd(CTRL_OFS, 32'h1, "ctrl_flush_reads0");
    wr(CTRL_OFS, 32'hF, 4'hF, "ctrl_k7");
    rd(CTRL_OFS, 32'h9, "ctrl_k_clamped");

    // Full FIFO: push and pop land on the same edge
    wr(CTRL_OFS, 32'h1, 4'hF, "ctrl_k0_again");
    for (int i = 0; i < 8; i++) drive_sample(sample_t'(10'h20 + i));
    idle(3);
    rd(STATUS_OFS, 32'h82, "status_full_no_ovf");
    drive_sample(10'h28);
    rd(DATA_OFS, 32'h20, "data_pop_with_push");
    rd(STATUS_OFS, 32'h82, "status_push_pop_full");

    // Byte select: only byte 1 written
    wr(CTRL_OFS, 32'h20E, 4'b0010, "ctrl_byte1");
    rd(CTRL_OFS, 32'h201, "ctrl_byte1_only");
    idle(2);
    check("irq_full_fifo", {31'd0, irq}, 32'd1);

    // Reset during a pending access
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF;
    adr = BASE | {28'd0, STATUS_OFS, 2'b00};
    rst = 1'b1;
    @(posedge clk); #1;
    check("ack_during_reset", {31'd0, ack}, 32'd0);
    check("irq_during_reset", {31'd0, irq}, 32'd0);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    idle(1);
    check("ack_after_reset", {31'd0, ack}, 32'd0);
    rd(STATUS_OFS, 32'h1, "status_after_midreset");
    rd(CTRL_OFS, 32'h0, "ctrl_after_midreset");

    // Threshold register (feature may be compiled out)
    wr(THRESH_OFS, 32'h0001_0200, 4'hF, "thresh_wr");
    rd(THRESH_OFS, THR_ON ? 32'h0001_0200 : 32'h0, "thresh_rd");
    wr(CTRL_OFS, 32'h201, 4'hF, "ctrl_thr");
    drive_sample(10'h1FF);
    idle(3);
    rd(STATUS_OFS, 32'h10, "status_below_thr");
    drive_sample(10'h200);
    idle(3);
    rd(STATUS_OFS, THR_ON ? 32'h28 : 32'h20, "status_at_thr");
    check("irq_thr", {31'd0, irq}, 32'd1);
    wr(STATUS_OFS, 32'h8, 4'hF, "status_thr_clear");
    rd(STATUS_OFS, 32'h20, "status_thr_cleared");
    rd(DATA_OFS, 32'h1FF, "data_thr_first");
    rd(DATA_OFS, 32'h200, "data_thr_second");
    check("irq_thr_idle", {31'd0, irq}, 32'd0);

    idle(2);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
